// File: rtl/fisnar_seq_pkg.sv
// Shared encodings for the Fisnar command sequencer: opcodes, FSM states,
// error codes and the cmd_word / status_word field layouts.
package fisnar_seq_pkg;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_DISPENSE  = 3'd1;
  localparam logic [2:0] OP_STEP      = 3'd2;
  localparam logic [2:0] OP_ABORT     = 3'd3;
  localparam logic [2:0] OP_CLEAR_ERR = 3'd4;

  // Argument sub-fields inside cmd_word[27:0]
  localparam int ARG_TICKS_W = 24;
  localparam int ARG_COUNT_W = 16;
  localparam int ARG_DIR_BIT = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DISP    = 3'd1,
    S_STEP_HI = 3'd2,
    S_STEP_LO = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_BUSY   = 2'd1,
    ERR_BAD_OP = 2'd2,
    ERR_ESTOP  = 2'd3
  } err_code_e;

  typedef struct packed {
    logic        toggle;    // [31]
    logic [2:0]  op;        // [30:28]
    logic [27:0] arg;       // [27:0]
  } cmd_t;

  typedef struct packed {
    logic        ack;       // [31]
    logic        busy;      // [30]
    logic        err;       // [29]
    err_code_e   code;      // [28:27]
    logic [2:0]  state;     // [26:24]
    logic [23:0] remaining; // [23:0]
  } status_t;

endpackage

// File: rtl/fisnar_seq_tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESCALE clocks, cleared by reset only.
module fisnar_seq_tick_gen #(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = $clog2(PRESCALE);

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/fisnar_cmd_sequencer.sv
// Toggle-handshaked command sequencer timing dispenser valve and stepper pulses.
// Optional FISNAR_SEQ_ESTOP_EN adds an active-low emergency stop input.
module fisnar_cmd_sequencer
  import fisnar_seq_pkg::*;
#(
  parameter int PRESCALE = 50,
  parameter int CNT_W    = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_word,
  output logic [31:0] status_word,
  output logic        valve_out,
  output logic        step_out,
  output logic        dir_out,
  output logic        busy
`ifdef FISNAR_SEQ_ESTOP_EN
  ,
  input  logic        estop_n
`endif
);

  cmd_t       cmd;
  state_e     state_q, state_d;
  err_code_e  code_q, code_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic       toggle_q, toggle_d;
  logic       err_q, err_d;
  logic       dir_d;
  logic       tick, accept, estop_act;
  status_t    status_d;
  logic       unused_arg_hi;

  assign cmd           = cmd_t'(cmd_word);
  assign unused_arg_hi = ^cmd.arg[27:ARG_TICKS_W];

`ifdef FISNAR_SEQ_ESTOP_EN
  assign estop_act = ~estop_n;
`else
  assign estop_act = 1'b0;
`endif

  fisnar_seq_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign accept    = (cmd.toggle != toggle_q);
  assign busy      = (state_q != S_IDLE);
  assign valve_out = (state_q == S_DISP);
  assign step_out  = (state_q == S_STEP_HI);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    toggle_d = toggle_q;
    err_d    = err_q;
    code_d   = code_q;
    dir_d    = dir_out;

    if (estop_act) begin
      // Commands are still acked so the HPS handshake never stalls, but ignored.
      toggle_d = cmd.toggle;
      state_d  = S_IDLE;
      rem_d    = '0;
      err_d    = 1'b1;
      code_d   = ERR_ESTOP;
    end else if (accept) begin
      // An accepted command swallows any coincident tick.
      toggle_d = cmd.toggle;
      case (cmd.op)
        OP_NOP: ;
        OP_ABORT: begin
          state_d = S_IDLE;
          rem_d   = '0;
        end
        OP_CLEAR_ERR: begin
          err_d  = 1'b0;
          code_d = ERR_NONE;
        end
        OP_DISPENSE, OP_STEP: begin
          if (busy) begin
            if (!err_q) begin
              err_d  = 1'b1;
              code_d = ERR_BUSY;
            end
          end else if (!err_q) begin
            if (cmd.op == OP_DISPENSE) begin
              if (cmd.arg[ARG_TICKS_W-1:0] != '0) begin
                state_d = S_DISP;
                rem_d   = CNT_W'(cmd.arg[ARG_TICKS_W-1:0]);
              end
            end else if (cmd.arg[ARG_COUNT_W-1:0] != '0) begin
              state_d = S_STEP_HI;
              rem_d   = CNT_W'(cmd.arg[ARG_COUNT_W-1:0]);
              dir_d   = cmd.arg[ARG_DIR_BIT];
            end
          end
        end
        // Illegal opcodes report BAD_OP even while busy: the more specific cause wins.
        default: begin
          if (!err_q) begin
            err_d  = 1'b1;
            code_d = ERR_BAD_OP;
          end
        end
      endcase
    end else if (tick) begin
      case (state_q)
        S_DISP: begin
          if (rem_q <= CNT_W'(1)) begin
            state_d = S_IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
        S_STEP_HI: state_d = S_STEP_LO;
        S_STEP_LO: begin
          if (rem_q <= CNT_W'(1)) begin
            state_d = S_IDLE;
            rem_d   = '0;
          end else begin
            state_d = S_STEP_HI;
            rem_d   = rem_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    // Status is built from next-state values so it tracks the registers with no extra lag.
    status_d.ack       = toggle_d;
    status_d.busy      = (state_d != S_IDLE);
    status_d.err       = err_d;
    status_d.code      = code_d;
    status_d.state     = state_d;
    status_d.remaining = 24'(rem_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      toggle_q    <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      dir_out     <= 1'b0;
      status_word <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      toggle_q    <= toggle_d;
      err_q       <= err_d;
      code_q      <= code_d;
      dir_out     <= dir_d;
      status_word <= status_d;
    end
  end

endmodule

// File: tb/tb_fisnar_cmd_sequencer.sv
// Directed self-checking bench for fisnar_cmd_sequencer with PRESCALE=4.
module tb_fisnar_cmd_sequencer;

  localparam int PRESCALE = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cmd_word;
  logic [31:0] status_word;
  logic        valve_out, step_out, dir_out, busy;
`ifdef FISNAR_SEQ_ESTOP_EN
  logic        estop_n;
`endif

  int   checks = 0;
  int   failures = 0;
  logic tg = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Mirror of the free-running prescaler phase, used to align commands with ticks.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  fisnar_cmd_sequencer #(.PRESCALE(PRESCALE), .CNT_W(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_word    (cmd_word),
    .status_word (status_word),
    .valve_out   (valve_out),
    .step_out    (step_out),
    .dir_out     (dir_out),
    .busy        (busy)
`ifdef FISNAR_SEQ_ESTOP_EN
    ,
    .estop_n     (estop_n)
`endif
  );

  task automatic send(input logic [2:0] op, input logic [27:0] arg);
    @(negedge clk);
    tg = ~tg;
    cmd_word = {tg, op, arg};
  endtask

  // Drive so the command is sampled on a tick cycle: then each phase lasts a full tick.
  task automatic send_aligned(input logic [2:0] op, input logic [27:0] arg);
    @(negedge clk);
    while (cyc % PRESCALE != PRESCALE - 1) @(negedge clk);
    tg = ~tg;
    cmd_word = {tg, op, arg};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cmd_word = '0;
    tg = 1'b0;
`ifdef FISNAR_SEQ_ESTOP_EN
    estop_n = 1'b1;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (status_word !== 32'h0 || valve_out !== 1'b0 || step_out !== 1'b0 ||
        dir_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs status=%h valve=%b step=%b dir=%b busy=%b expected all zero",
               status_word, valve_out, step_out, dir_out, busy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (status_word !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_spurious status=%h busy=%b expected 0/0", status_word, busy);
    end
  endtask

  task automatic test_dispense;
    int n;
    send_aligned(3'd1, 28'd3);
    @(negedge clk);
    checks++;
    if (status_word[31] !== 1'b1 || status_word[26:24] !== 3'd1 ||
        status_word[23:0] !== 24'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL disp_start ack=%b state=%0d rem=%0d busy=%b expected 1/1/3/1",
               status_word[31], status_word[26:24], status_word[23:0], busy);
    end
    n = valve_out ? 1 : 0;
    for (int i = 0; i < 40 && busy; i++) begin
      @(negedge clk);
      if (valve_out) n++;
    end
    checks++;
    if (n != 12) begin
      failures++;
      $display("FAIL disp_width valve_high=%0d expected 12", n);
    end
    checks++;
    if (busy !== 1'b0 || status_word[23:0] !== 24'd0 || status_word[26:24] !== 3'd0) begin
      failures++;
      $display("FAIL disp_end busy=%b rem=%0d state=%0d expected 0/0/0",
               busy, status_word[23:0], status_word[26:24]);
    end
  endtask

  task automatic test_step;
    logic [19:0] got, exp;
    logic        dir_seen;
    send_aligned(3'd2, 28'h001_0002);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got[i] = step_out;
      exp[i] = (i < 4) || (i >= 8 && i < 12);
      if (i == 0) dir_seen = dir_out;
    end
    checks++;
    if (dir_seen !== 1'b1) begin
      failures++;
      $display("FAIL step_dir dir=%b expected 1", dir_seen);
    end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL step_pattern got=%b expected=%b", got, exp);
    end
    checks++;
    if (busy !== 1'b0 || status_word[26:24] !== 3'd0) begin
      failures++;
      $display("FAIL step_end busy=%b state=%0d expected 0/0", busy, status_word[26:24]);
    end
  endtask

  task automatic test_abort;
    send(3'd1, 28'd1000);
    repeat (20) @(negedge clk);
    checks++;
    if (valve_out !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre valve=%b expected 1", valve_out);
    end
    send(3'd3, 28'd0);
    @(negedge clk);
    checks++;
    if (valve_out !== 1'b0 || busy !== 1'b0 || status_word[26:24] !== 3'd0 ||
        status_word[29] !== 1'b0 || status_word[23:0] !== 24'd0 || status_word[31] !== tg) begin
      failures++;
      $display("FAIL abort valve=%b busy=%b state=%0d err=%b rem=%0d ack=%b expected 0/0/0/0/0/%b",
               valve_out, busy, status_word[26:24], status_word[29], status_word[23:0],
               status_word[31], tg);
    end
  endtask

  task automatic test_busy_err;
    int   rises;
    logic prev, vseen;
    send(3'd2, 28'd2);
    rises = 0;
    prev  = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (step_out && !prev) rises++;
      prev = step_out;
      if (k == 2) begin
        tg = ~tg;
        cmd_word = {tg, 3'd1, 28'd5};
      end
      if (k == 3) begin
        checks++;
        if (status_word[29] !== 1'b1 || status_word[28:27] !== 2'b01 || busy !== 1'b1 ||
            valve_out !== 1'b0) begin
          failures++;
          $display("FAIL busy_err err=%b code=%b busy=%b valve=%b expected 1/01/1/0",
                   status_word[29], status_word[28:27], busy, valve_out);
        end
      end
      if (k > 3 && !busy) break;
    end
    checks++;
    if (rises != 2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_steps rises=%0d busy=%b expected 2/0", rises, busy);
    end
    send(3'd1, 28'd5);
    vseen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vseen |= valve_out | busy;
    end
    checks++;
    if (status_word[31] !== tg || vseen !== 1'b0 || status_word[29] !== 1'b1) begin
      failures++;
      $display("FAIL err_ignore ack=%b active=%b err=%b expected %b/0/1",
               status_word[31], vseen, status_word[29], tg);
    end
    send(3'd4, 28'd0);
    @(negedge clk);
    checks++;
    if (status_word[29] !== 1'b0 || status_word[28:27] !== 2'b00) begin
      failures++;
      $display("FAIL clear_err err=%b code=%b expected 0/00", status_word[29], status_word[28:27]);
    end
  endtask

  task automatic test_bad_op_zero;
    logic vseen;
    send(3'd6, 28'd0);
    @(negedge clk);
    checks++;
    if (status_word[29] !== 1'b1 || status_word[28:27] !== 2'b10 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_op err=%b code=%b busy=%b expected 1/10/0",
               status_word[29], status_word[28:27], busy);
    end
    send(3'd4, 28'd0);
    @(negedge clk);
    send(3'd1, 28'd0);
    @(negedge clk);
    checks++;
    if (status_word[31] !== tg || status_word[29] !== 1'b0 || status_word[26:24] !== 3'd0) begin
      failures++;
      $display("FAIL zero_disp ack=%b err=%b state=%0d expected %b/0/0",
               status_word[31], status_word[29], status_word[26:24], tg);
    end
    vseen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vseen |= valve_out | busy;
    end
    checks++;
    if (vseen !== 1'b0) begin
      failures++;
      $display("FAIL zero_disp_pulse active=%b expected 0", vseen);
    end
  endtask

`ifdef FISNAR_SEQ_ESTOP_EN
  task automatic test_estop;
    send(3'd1, 28'd100);
    repeat (5) @(negedge clk);
    estop_n = 1'b0;
    @(negedge clk);
    checks++;
    if (valve_out !== 1'b0 || busy !== 1'b0 || status_word[29] !== 1'b1 ||
        status_word[28:27] !== 2'b11) begin
      failures++;
      $display("FAIL estop valve=%b busy=%b err=%b code=%b expected 0/0/1/11",
               valve_out, busy, status_word[29], status_word[28:27]);
    end
    repeat (3) @(negedge clk);
    estop_n = 1'b1;
    send(3'd1, 28'd10);
    repeat (3) @(negedge clk);
    checks++;
    if (valve_out !== 1'b0 || busy !== 1'b0 || status_word[29] !== 1'b1) begin
      failures++;
      $display("FAIL estop_release valve=%b busy=%b err=%b expected 0/0/1",
               valve_out, busy, status_word[29]);
    end
    send(3'd4, 28'd0);
    @(negedge clk);
    checks++;
    if (status_word[29] !== 1'b0 || status_word[28:27] !== 2'b00) begin
      failures++;
      $display("FAIL estop_clear err=%b code=%b expected 0/00", status_word[29], status_word[28:27]);
    end
  endtask
`endif

  task automatic test_reset_mid_step;
    send(3'd2, 28'h001_0005);
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || dir_out !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre busy=%b dir=%b expected 1/1", busy, dir_out);
    end
    reset = 1'b1;
    tg = 1'b0;
    cmd_word = '0;
    @(negedge clk);
    checks++;
    if (status_word !== 32'h0 || valve_out !== 1'b0 || step_out !== 1'b0 ||
        dir_out !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid status=%h valve=%b step=%b dir=%b busy=%b expected all zero",
               status_word, valve_out, step_out, dir_out, busy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_dispense;
    test_step;
    test_abort;
    test_busy_err;
    test_bad_op_zero;
`ifdef FISNAR_SEQ_ESTOP_EN
    test_estop;
`endif
    test_reset_mid_step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
